obstacle_spawner: RTL and testbench

Upstream stage of the obstacle controller: decides when a new obstacle enters the playfield, what type it is and at which x column. Counts frame ticks against a spawn interval, draws a pseudo-random column and type from a 16-bit LFSR, and presents them to the obstacle controller. The presented values are held until the controller acknowledges them. With difficulty enabled, the interval shrinks as spawns accumulate.

---
 rtl/obstacle_pkg.sv | 36 +++
 rtl/obstacle_spawner_if.sv | 21 ++
 rtl/obstacle_spawner_lfsr16.sv | 19 +
 rtl/obstacle_spawner.sv | 134 +++++++++++++
 tb/tb_obstacle_spawner.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/obstacle_pkg.sv
// Shared definitions for the obstacle spawner and the obstacle controller:
// FSM states, obstacle type codes, playfield geometry and LFSR helpers.
package obstacle_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    ISSUE = 2'd2
  } state_e;

  localparam logic [1:0] OBST_NONE = 2'd0;
  localparam logic [1:0] OBST_ROCK = 2'd1;
  localparam logic [1:0] OBST_LOG  = 2'd2;
  localparam logic [1:0] OBST_CAR  = 2'd3;

  localparam int SCREEN_W_DEF = 640;
  localparam int OBST_W_DEF   = 32;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // One step of the right-shifting Galois LFSR.
  function automatic logic [15:0] galois_step(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

  // Obstacle type from LFSR bits [11:10]; code 0 would mean "no spawn", so it becomes a rock.
  function automatic logic [1:0] map_type(input logic [15:0] l);
    return (l[11:10] == OBST_NONE) ? OBST_ROCK : l[11:10];
  endfunction

  // Start column from LFSR bits [9:0], folded back into the legal range 0..span-1.
  function automatic logic [9:0] map_x(input logic [15:0] l, input logic [9:0] span);
    return (l[9:0] >= span) ? (l[9:0] - span) : l[9:0];
  endfunction

endpackage

// File: rtl/obstacle_spawner_if.sv
// Spawner <-> game/controller signal bundle. The spawner uses the slave
// modport; whoever drives enable, frame_tick and ack uses master.
interface obstacle_spawner_if;
  logic       enable;
  logic       frame_tick;
  logic       obstacle_ack;
  logic [1:0] obstacle_trigger;
  logic [9:0] obstacle_start_x;
  logic [7:0] spawn_count;
  logic [7:0] interval;

  modport master (
    output enable, frame_tick, obstacle_ack,
    input  obstacle_trigger, obstacle_start_x, spawn_count, interval
  );

  modport slave (
    input  enable, frame_tick, obstacle_ack,
    output obstacle_trigger, obstacle_start_x, spawn_count, interval
  );
endinterface

// File: rtl/obstacle_spawner_lfsr16.sv
// 16-bit Galois LFSR (taps 16'hB400, shift right) that advances when step is high.
module lfsr16
  import obstacle_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        step,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  // Sequence register; the seed must be non-zero or the LFSR locks up.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    q <= seed;
    else if (step) q <= galois_step(q);
  end

endmodule

// File: rtl/obstacle_spawner.sv
// Obstacle spawner: counts frame ticks against the spawn interval, then
// presents a pseudo-random obstacle type and start column until the
// controller acknowledges it.
// Optional feature: define OBSTACLE_SPAWNER_DIFFICULTY_EN to shrink the
// interval by INTERVAL_STEP (floored at MIN_INTERVAL) every 8th spawn.
module obstacle_spawner
  import obstacle_pkg::*;
#(
  parameter int          SCREEN_W      = SCREEN_W_DEF,
  parameter int          OBST_W        = OBST_W_DEF,
  parameter int          INIT_INTERVAL = 120,
  parameter int          MIN_INTERVAL  = 30,
  parameter int          INTERVAL_STEP = 5,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input logic                CLOCK_50,
  input logic                reset,
  obstacle_spawner_if.slave  bus
);

  localparam logic [9:0] X_SPAN  = 10'(SCREEN_W - OBST_W);
  localparam logic [7:0] INIT_IV = 8'(INIT_INTERVAL);

  if (INIT_INTERVAL < 1 || INIT_INTERVAL > 255 || MIN_INTERVAL < 1 ||
      MIN_INTERVAL > INIT_INTERVAL || INTERVAL_STEP < 0 || LFSR_SEED == 16'h0000) begin : g_bad_cfg
    $error("obstacle_spawner: illegal interval or seed parameters");
  end

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  trig_q, trig_d;
  logic [9:0]  x_q, x_d;
  logic [7:0]  count_q, count_d;
  logic [7:0]  interval_q, interval_d;
  logic [15:0] lfsr_q, lfsr_next;
  logic        lfsr_step;

  // The LFSR only moves on frame ticks while the game is running.
  assign lfsr_step = bus.enable && bus.frame_tick && (state_q != IDLE);
  assign lfsr_next = galois_step(lfsr_q);

  lfsr16 u_lfsr (
    .clk   (CLOCK_50),
    .reset (reset),
    .step  (lfsr_step),
    .seed  (LFSR_SEED),
    .q     (lfsr_q)
  );

`ifdef OBSTACLE_SPAWNER_DIFFICULTY_EN
  logic [8:0] interval_dec;
  // 9-bit subtraction: bit 8 set means the step went below zero.
  assign interval_dec = {1'b0, interval_q} - 9'(INTERVAL_STEP);
`endif

  // Next-state, countdown, spawn capture and acknowledge handling.
  always_comb begin
    // NOTE: every target gets a default first so no path leaves one unassigned (no latches).
    state_d    = state_q;
    cnt_d      = cnt_q;
    trig_d     = trig_q;
    x_d        = x_q;
    count_d    = count_q;
    interval_d = interval_q;

    if (!bus.enable) begin
      state_d = IDLE;
      cnt_d   = '0;
      trig_d  = OBST_NONE;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = COUNT;
          cnt_d   = interval_q;
        end
        COUNT: begin
          if (bus.frame_tick) begin
            if (cnt_q == 8'd1) begin
              state_d = ISSUE;
              cnt_d   = '0;
              trig_d  = map_type(lfsr_next);
              x_d     = map_x(lfsr_next, X_SPAN);
            end else begin
              cnt_d = cnt_q - 8'd1;
            end
          end
        end
        ISSUE: begin
          // A tick in the same cycle only moves the LFSR; the reload ignores it.
          if (bus.obstacle_ack) begin
            state_d = COUNT;
            trig_d  = OBST_NONE;
            count_d = count_q + 8'd1;
`ifdef OBSTACLE_SPAWNER_DIFFICULTY_EN
            if (count_d[2:0] == 3'd0) begin
              if (interval_dec[8] || (interval_dec < 9'(MIN_INTERVAL)))
                interval_d = 8'(MIN_INTERVAL);
              else
                interval_d = interval_dec[7:0];
            end
`endif
            cnt_d = interval_d;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      trig_q     <= OBST_NONE;
      x_q        <= '0;
      count_q    <= '0;
      interval_q <= INIT_IV;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      trig_q     <= trig_d;
      x_q        <= x_d;
      count_q    <= count_d;
      interval_q <= interval_d;
    end
  end

  assign bus.obstacle_trigger = trig_q;
  assign bus.obstacle_start_x = x_q;
  assign bus.spawn_count      = count_q;
  assign bus.interval         = interval_q;

endmodule

// File: tb/tb_obstacle_spawner.sv
// Directed bench for obstacle_spawner. Three instances:
//   a: INIT_INTERVAL=3, default seed -- timing, hold, ack, enable, reset cases
//   b: INIT=40, MIN=30, STEP=5       -- difficulty ramp over 24 acks
//   c: INIT=1, seed 16'h07FE         -- first step gives L=16'h03FF (x=1023, type code 0)
module tb_obstacle_spawner;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  obstacle_spawner_if ia ();
  obstacle_spawner_if ib ();
  obstacle_spawner_if ic ();

  obstacle_spawner #(.INIT_INTERVAL(3)) dut_a (
    .CLOCK_50 (clk),
    .reset    (rst_n),
    .bus      (ia.slave)
  );

  obstacle_spawner #(.INIT_INTERVAL(40), .MIN_INTERVAL(30), .INTERVAL_STEP(5)) dut_b (
    .CLOCK_50 (clk),
    .reset    (rst_n),
    .bus      (ib.slave)
  );

  obstacle_spawner #(.INIT_INTERVAL(1), .LFSR_SEED(16'h07FE)) dut_c (
    .CLOCK_50 (clk),
    .reset    (rst_n),
    .bus      (ic.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Frame tick on instance a, four clocks apart; returns one clock after the tick edge.
  task automatic tick_a();
    repeat (3) @(negedge clk);
    ia.frame_tick = 1'b1;
    @(negedge clk);
    ia.frame_tick = 1'b0;
  endtask

  task automatic ack_a();
    @(negedge clk);
    ia.obstacle_ack = 1'b1;
    @(negedge clk);
    ia.obstacle_ack = 1'b0;
  endtask

  // Three ticks after (re)entering COUNT: no trigger after two, trigger after the third.
  task automatic full_interval_a(input string tag);
    tick_a();
    tick_a();
    check({tag, "_early"}, 32'(ia.obstacle_trigger), 0);
    tick_a();
    check({tag, "_fire"}, 32'(ia.obstacle_trigger != 2'd0), 1);
  endtask

  initial begin
    int  wait_cyc;
    bit  timed_out;

    rst_n = 1'b0;
    ia.enable = 1'b0; ia.frame_tick = 1'b0; ia.obstacle_ack = 1'b0;
    ib.enable = 1'b0; ib.frame_tick = 1'b0; ib.obstacle_ack = 1'b0;
    ic.enable = 1'b0; ic.frame_tick = 1'b0; ic.obstacle_ack = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values.
    check("rst_trigger",  32'(ia.obstacle_trigger), 0);
    check("rst_start_x",  32'(ia.obstacle_start_x), 0);
    check("rst_count",    32'(ia.spawn_count), 0);
    check("rst_interval", 32'(ia.interval), 3);
    check("rst_interval_b", 32'(ib.interval), 40);
    rst_n = 1'b1;

    // First spawn: seed ACE1 -> E270 -> 7138 -> 389C; type=2, x=0x09C=156.
    @(negedge clk);
    ia.enable = 1'b1;
    @(negedge clk);
    tick_a();
    tick_a();
    check("first_early", 32'(ia.obstacle_trigger), 0);
    tick_a();
    check("first_type", 32'(ia.obstacle_trigger), 2);
    check("first_x",    32'(ia.obstacle_start_x), 156);
    check("first_x_legal", 32'(ia.obstacle_start_x < 10'd608), 1);

    // Held with no ack while ticks keep coming.
    for (int i = 0; i < 12; i++) tick_a();
    repeat (2) @(negedge clk);
    check("hold_type", 32'(ia.obstacle_trigger), 2);
    check("hold_x",    32'(ia.obstacle_start_x), 156);

    // Release.
    ack_a();
    check("ack_trigger", 32'(ia.obstacle_trigger), 0);
    check("ack_count",   32'(ia.spawn_count), 1);

    // Stray ack in COUNT is ignored.
    ack_a();
    check("stray_ack_count", 32'(ia.spawn_count), 1);
    check("stray_ack_trig",  32'(ia.obstacle_trigger), 0);

    // Drop enable mid-COUNT (after one tick), then re-enable: full interval again.
    tick_a();
    @(negedge clk);
    ia.enable = 1'b0;
    @(negedge clk);
    check("dis_count_trig", 32'(ia.obstacle_trigger), 0);
    ia.enable = 1'b1;
    @(negedge clk);
    full_interval_a("reen_count");

    // Drop enable mid-ISSUE.
    @(negedge clk);
    ia.enable = 1'b0;
    @(negedge clk);
    check("dis_issue_trig",  32'(ia.obstacle_trigger), 0);
    check("dis_issue_count", 32'(ia.spawn_count), 1);
    ia.enable = 1'b1;
    @(negedge clk);
    full_interval_a("reen_issue");

    // Ack and tick together in ISSUE: ack wins, reload ignores the tick.
    @(negedge clk);
    ia.obstacle_ack = 1'b1;
    ia.frame_tick   = 1'b1;
    @(negedge clk);
    ia.obstacle_ack = 1'b0;
    ia.frame_tick   = 1'b0;
    check("ack_tick_trig",  32'(ia.obstacle_trigger), 0);
    check("ack_tick_count", 32'(ia.spawn_count), 2);
    full_interval_a("ack_tick_reload");
    check("a_interval_const", 32'(ia.interval), 3);

    // Fold boundary: L=03FF -> x=1023-608=415, type code 0 -> 1.
    ic.enable = 1'b1;
    @(negedge clk);
    ic.frame_tick = 1'b1;
    @(negedge clk);
    ic.frame_tick = 1'b0;
    check("fold_type", 32'(ic.obstacle_trigger), 1);
    check("fold_x",    32'(ic.obstacle_start_x), 415);

    // Difficulty ramp with ticks every clock.
    ib.enable     = 1'b1;
    ib.frame_tick = 1'b1;
    timed_out     = 1'b0;
    for (int i = 0; i < 24 && !timed_out; i++) begin
      wait_cyc = 0;
      while (ib.obstacle_trigger == 2'd0 && wait_cyc < 200) begin
        @(negedge clk);
        wait_cyc++;
      end
      if (wait_cyc >= 200) timed_out = 1'b1;
      else begin
        ib.obstacle_ack = 1'b1;
        @(negedge clk);
        ib.obstacle_ack = 1'b0;
`ifdef OBSTACLE_SPAWNER_DIFFICULTY_EN
        if (i == 7)  check("diff_iv_8",  32'(ib.interval), 35);
        if (i == 15) check("diff_iv_16", 32'(ib.interval), 30);
        if (i == 23) check("diff_iv_24", 32'(ib.interval), 30);
`else
        if (i == 7)  check("const_iv_8",  32'(ib.interval), 40);
        if (i == 15) check("const_iv_16", 32'(ib.interval), 40);
        if (i == 23) check("const_iv_24", 32'(ib.interval), 40);
`endif
      end
    end
    check("diff_timeout", 32'(timed_out), 0);
    check("diff_count",   32'(ib.spawn_count), 24);
    ib.frame_tick = 1'b0;

    // Reset asserted mid-ISSUE clears trigger without waiting for a clock.
    check("pre_rst_trig", 32'(ia.obstacle_trigger != 2'd0), 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_trig",  32'(ia.obstacle_trigger), 0);
    check("async_rst_count", 32'(ia.spawn_count), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
